// File: rtl/frame_seq_pkg.sv
// Shared types and widths for the frame-read sequencer: FSM state encoding
// and the row/column/sync counter widths.
package frame_seq_pkg;

  localparam int ROW_W  = 10;
  localparam int COL_W  = 11;
  localparam int SYNC_W = 9;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_VSYNC = 2'b01,
    S_HSYNC = 2'b10,
    S_DATA  = 2'b11
  } state_e;

endpackage

// File: rtl/frame_seq_timer.sv
// Loadable down-counter with terminal-count flag and synchronous clear; times
// both the VSYNC start-up interval and the per-line HSYNC blanking interval.
module frame_seq_timer
  import frame_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              load_i,
  input  logic [SYNC_W-1:0] load_val_i,
  input  logic              en_i,
  output logic              tc_o
);

  logic [SYNC_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && !tc_o) begin
      cnt_d = cnt_q - SYNC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/frame_read_sequencer.sv
// Stallable, abortable full-frame readout scheduler: VSYNC start-up, then per
// line HSYNC blanking followed by pixel-pair addresses. Define ROW_FLIP_EN to
// address lines bottom-up (line_base counts down from the last line).
module frame_read_sequencer
  import frame_seq_pkg::*;
#(
  parameter int WIDTH          = 768,
  parameter int HEIGHT         = 512,
  parameter int START_UP_DELAY = 100,
  parameter int HSYNC_DELAY    = 160,
  parameter int ADDR_W         = 19
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              start,
  input  logic              abort,
  output logic              VSYNC,
  output logic              HSYNC,
  output logic              busy,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [ADDR_W-1:0] pix_addr,
  output logic [ROW_W-1:0]  pix_row,
  output logic [COL_W-1:0]  pix_col,
  output logic              pix_sol,
  output logic              pix_eol,
  output logic              pix_eof,
  output logic              ctrl_done
);

  // Timer holds DELAY-1 so the terminal count lands on the last interval cycle.
  localparam logic [SYNC_W-1:0] SU_LOAD   = SYNC_W'(START_UP_DELAY - 1);
  localparam logic [SYNC_W-1:0] HS_LOAD   = SYNC_W'(HSYNC_DELAY - 1);
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(WIDTH - 2);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(HEIGHT - 1);
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(WIDTH);
`ifdef ROW_FLIP_EN
  localparam logic [ADDR_W-1:0] BASE_INIT = ADDR_W'((HEIGHT - 1) * WIDTH);
`else
  localparam logic [ADDR_W-1:0] BASE_INIT = '0;
`endif

  state_e            state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              done_q, done_d;

  logic              tmr_clr, tmr_load, tmr_en, tmr_tc;
  logic [SYNC_W-1:0] tmr_val;
  logic              xfer;

  assign xfer = pix_valid & pix_ready;

  frame_seq_timer u_timer (
    .clk        (HCLK),
    .rst_n      (HRESETn),
    .clr_i      (tmr_clr),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .en_i       (tmr_en),
    .tc_o       (tmr_tc)
  );

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    base_d   = base_q;
    done_d   = 1'b0;
    tmr_clr  = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = SU_LOAD;
    tmr_en   = 1'b0;

    if (abort) begin
      state_d = S_IDLE;
      col_d   = '0;
      row_d   = '0;
      base_d  = '0;
      tmr_clr = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d  = S_VSYNC;
            base_d   = BASE_INIT;
            tmr_load = 1'b1;
          end
        end
        S_VSYNC: begin
          tmr_en = 1'b1;
          if (tmr_tc) begin
            state_d  = S_HSYNC;
            tmr_load = 1'b1;
            tmr_val  = HS_LOAD;
          end
        end
        S_HSYNC: begin
          tmr_en = 1'b1;
          if (tmr_tc) begin
            state_d = S_DATA;
          end
        end
        S_DATA: begin
          if (xfer) begin
            if (col_q == COL_LAST) begin
              col_d = '0;
              if (row_q == ROW_LAST) begin
                // Frame finished: return to a clean IDLE so a new start needs no cleanup.
                state_d = S_IDLE;
                done_d  = 1'b1;
                row_d   = '0;
                base_d  = '0;
              end else begin
                state_d  = S_HSYNC;
                row_d    = row_q + ROW_W'(1);
                tmr_load = 1'b1;
                tmr_val  = HS_LOAD;
`ifdef ROW_FLIP_EN
                base_d   = base_q - LINE_STEP;
`else
                base_d   = base_q + LINE_STEP;
`endif
              end
            end else begin
              col_d = col_q + COL_W'(2);
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      base_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      base_q  <= base_d;
      done_q  <= done_d;
    end
  end

  assign pix_valid = (state_q == S_DATA);
  assign HSYNC     = pix_valid;
  assign VSYNC     = (state_q == S_VSYNC);
  assign busy      = (state_q != S_IDLE);
  assign pix_addr  = pix_valid ? (base_q + ADDR_W'(col_q)) : '0;
  assign pix_row   = row_q;
  assign pix_col   = col_q;
  assign pix_sol   = pix_valid & (col_q == '0);
  assign pix_eol   = pix_valid & (col_q == COL_LAST);
  assign pix_eof   = pix_eol & (row_q == ROW_LAST);
  assign ctrl_done = done_q;

endmodule

// File: tb/tb_frame_read_sequencer.sv
// Self-checking bench for frame_read_sequencer (WIDTH=8, HEIGHT=4, delays 3/2).
// Expected pair sequence comes from a row/column walk of the frame.
module tb_frame_read_sequencer;

  localparam int WIDTH  = 8;
  localparam int HEIGHT = 4;
  localparam int SU     = 3;
  localparam int HS     = 2;
  localparam int ADDR_W = 5;
  localparam int NOM_BUSY = SU + HEIGHT * (HS + WIDTH / 2);

  logic              HCLK = 1'b0;
  logic              HRESETn = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              pix_ready = 1'b0;
  logic              VSYNC, HSYNC, busy, pix_valid;
  logic [ADDR_W-1:0] pix_addr;
  logic [9:0]        pix_row;
  logic [10:0]       pix_col;
  logic              pix_sol, pix_eol, pix_eof, ctrl_done;

  int n_cmp = 0;
  int n_err = 0;

  int busy_mon = 0;
  int xq[$];
  bit last_eof;

  frame_read_sequencer #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .START_UP_DELAY(SU),
    .HSYNC_DELAY(HS), .ADDR_W(ADDR_W)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .start(start), .abort(abort),
    .VSYNC(VSYNC), .HSYNC(HSYNC), .busy(busy), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .pix_addr(pix_addr), .pix_row(pix_row),
    .pix_col(pix_col), .pix_sol(pix_sol), .pix_eol(pix_eol),
    .pix_eof(pix_eof), .ctrl_done(ctrl_done)
  );

  always #5 HCLK = ~HCLK;

  always @(negedge HCLK) begin
    if (busy) busy_mon++;
    if (HRESETn && pix_valid && pix_ready) begin
      xq.push_back(int'(pix_addr));
      last_eof = pix_eof;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  function automatic int exp_addr(input int r, input int c);
`ifdef ROW_FLIP_EN
    return (HEIGHT - 1 - r) * WIDTH + c;
`else
    return r * WIDTH + c;
`endif
  endfunction

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  // Walks one frame cycle by cycle against the expected timeline.
  task automatic run_frame(input string tag, input int rdy_pct,
                           input int stall_addr, input int stall_len,
                           input int abort_r, input int abort_c,
                           input int ign_r, input int rst_r, input int rst_c,
                           input bit skip_start, input bit b2b);
    int stalls;
    int run;
    int c;
    bit rdy;
    bit quit;
    logic [28:0] got, exp;
    stalls = 0;
    quit = 1'b0;
    if (!skip_start) begin
      n_cmp++;
      if (busy !== 1'b0) begin
        n_err++; $display("FAIL %s_idle_before_start: busy=%b want 0", tag, busy);
      end
      start = 1'b1;
      step();
      start = 1'b0;
    end
    for (int i = 0; i < SU; i++) begin
      n_cmp++;
      if ({VSYNC, HSYNC, busy, pix_valid} !== 4'b1010) begin
        n_err++; $display("FAIL %s_vsync[%0d]: flags=%b want 1010", tag, i, {VSYNC, HSYNC, busy, pix_valid});
      end
      step();
    end
    for (int r = 0; r < HEIGHT && !quit; r++) begin
      for (int h = 0; h < HS; h++) begin
        n_cmp++;
        if ({VSYNC, HSYNC, busy, pix_valid, ctrl_done} !== 5'b00100) begin
          n_err++; $display("FAIL %s_hsync r%0d[%0d]: flags=%b want 00100", tag, r, h, {VSYNC, HSYNC, busy, pix_valid, ctrl_done});
        end
        if (r == ign_r && h == 0) start = 1'b1;
        step();
        start = 1'b0;
      end
      c = 0;
      run = 0;
      while (c < WIDTH && !quit) begin
        rdy = ($urandom_range(0, 99) < rdy_pct) || (run >= 6);
        if (exp_addr(r, c) == stall_addr && stalls < stall_len) begin
          rdy = 1'b0;
          stalls++;
        end
        pix_ready = rdy;
        n_cmp++;
        if ({VSYNC, HSYNC, busy, pix_valid, ctrl_done} !== 5'b01110) begin
          n_err++; $display("FAIL %s_data_flags r%0d c%0d: flags=%b want 01110", tag, r, c, {VSYNC, HSYNC, busy, pix_valid, ctrl_done});
        end
        got = {pix_addr, pix_row, pix_col, pix_sol, pix_eol, pix_eof};
        exp = {ADDR_W'(exp_addr(r, c)), 10'(r), 11'(c), (c == 0), (c == WIDTH - 2),
               (r == HEIGHT - 1 && c == WIDTH - 2)};
        n_cmp++;
        if (got !== exp) begin
          n_err++; $display("FAIL %s_pair r%0d c%0d: addr/row/col/sol/eol/eof=%h want %h", tag, r, c, got, exp);
        end
        if (r == rst_r && c == rst_c) begin
          #2 HRESETn = 1'b0;
          #1;
          n_cmp++;
          if ({VSYNC, HSYNC, busy, pix_valid, pix_addr, pix_row, pix_col, pix_sol, pix_eol, pix_eof, ctrl_done} !== '0) begin
            n_err++; $display("FAIL %s_async_reset: outputs=%h want 0", tag,
              {VSYNC, HSYNC, busy, pix_valid, pix_addr, pix_row, pix_col, pix_sol, pix_eol, pix_eof, ctrl_done});
          end
          #2 HRESETn = 1'b1;
          step();
          n_cmp++;
          if ({busy, pix_valid, ctrl_done} !== 3'b000) begin
            n_err++; $display("FAIL %s_after_reset: busy/valid/done=%b want 000", tag, {busy, pix_valid, ctrl_done});
          end
          quit = 1'b1;
        end else if (r == abort_r && c == abort_c) begin
          abort = 1'b1;
          pix_ready = 1'b1;
          step();
          abort = 1'b0;
          n_cmp++;
          if ({VSYNC, HSYNC, busy, pix_valid, ctrl_done, pix_addr} !== '0) begin
            n_err++; $display("FAIL %s_abort_idle: flags=%b addr=%0d want 0", tag, {VSYNC, HSYNC, busy, pix_valid, ctrl_done}, pix_addr);
          end
          step();
          n_cmp++;
          if ({busy, ctrl_done} !== 2'b00) begin
            n_err++; $display("FAIL %s_abort_no_done: busy/done=%b want 00", tag, {busy, ctrl_done});
          end
          quit = 1'b1;
        end else begin
          step();
          if (rdy) begin
            c += 2;
            run = 0;
          end else begin
            run++;
          end
        end
      end
    end
    if (!quit) begin
      n_cmp++;
      if ({VSYNC, HSYNC, busy, pix_valid, ctrl_done} !== 5'b00001) begin
        n_err++; $display("FAIL %s_done_cycle: flags=%b want 00001", tag, {VSYNC, HSYNC, busy, pix_valid, ctrl_done});
      end
      if (b2b) start = 1'b1;
      step();
      start = 1'b0;
      n_cmp++;
      if ({VSYNC, busy, ctrl_done} !== (b2b ? 3'b110 : 3'b000)) begin
        n_err++; $display("FAIL %s_after_done: vsync/busy/done=%b want %b", tag, {VSYNC, busy, ctrl_done}, (b2b ? 3'b110 : 3'b000));
      end
    end
  endtask

  task automatic test_reset();
    #3;
    n_cmp++;
    if ({VSYNC, HSYNC, busy, pix_valid, pix_addr, pix_row, pix_col, pix_sol, pix_eol, pix_eof, ctrl_done} !== '0) begin
      n_err++; $display("FAIL reset_outputs: got %h want 0",
        {VSYNC, HSYNC, busy, pix_valid, pix_addr, pix_row, pix_col, pix_sol, pix_eol, pix_eof, ctrl_done});
    end
    @(negedge HCLK);
    HRESETn = 1'b1;
    step();
    step();
    n_cmp++;
    if ({busy, pix_valid, ctrl_done} !== 3'b000) begin
      n_err++; $display("FAIL reset_release_idle: busy/valid/done=%b want 000", {busy, pix_valid, ctrl_done});
    end
  endtask

  task automatic test_nominal();
    int b0, x0;
    b0 = busy_mon;
    x0 = xq.size();
    run_frame("nominal", 100, -1, 0, -1, -1, -1, -1, -1, 1'b0, 1'b0);
    n_cmp++;
    if (busy_mon - b0 !== NOM_BUSY) begin
      n_err++; $display("FAIL nominal_busy_cycles: got %0d want %0d", busy_mon - b0, NOM_BUSY);
    end
    n_cmp++;
    if (xq.size() - x0 !== 16) begin
      n_err++; $display("FAIL nominal_transfers: got %0d want 16", xq.size() - x0);
    end
    n_cmp++;
    if (xq[xq.size() - 1] !== exp_addr(HEIGHT - 1, WIDTH - 2) || last_eof !== 1'b1) begin
      n_err++; $display("FAIL nominal_last_pair: addr=%0d eof=%b want %0d/1", xq[xq.size() - 1], last_eof, exp_addr(HEIGHT - 1, WIDTH - 2));
    end
  endtask

  task automatic test_backpressure();
    int b0;
    b0 = busy_mon;
    run_frame("bp", 100, 10, 5, -1, -1, -1, -1, -1, 1'b0, 1'b0);
    n_cmp++;
    if (busy_mon - b0 !== NOM_BUSY + 5) begin
      n_err++; $display("FAIL bp_busy_cycles: got %0d want %0d", busy_mon - b0, NOM_BUSY + 5);
    end
  endtask

  task automatic test_line_bases();
    int x0;
    int first, line1, last;
`ifdef ROW_FLIP_EN
    first = 24; line1 = 16; last = 6;
`else
    first = 0; line1 = 8; last = 30;
`endif
    x0 = xq.size();
    run_frame("bases", 100, -1, 0, -1, -1, -1, -1, -1, 1'b0, 1'b0);
    n_cmp++;
    if (xq.size() - x0 !== 16 || xq[x0] !== first || xq[x0 + 4] !== line1 || xq[x0 + 15] !== last) begin
      n_err++; $display("FAIL line_bases: n=%0d first=%0d line1=%0d last=%0d want 16/%0d/%0d/%0d",
        xq.size() - x0, xq[x0], xq[x0 + 4], xq[x0 + 15], first, line1, last);
    end
  endtask

  task automatic test_abort();
    int x0;
    x0 = xq.size();
    run_frame("abort", 100, -1, 0, 2, 4, -1, -1, -1, 1'b0, 1'b0);
    n_cmp++;
    if (xq.size() - x0 !== 11) begin
      n_err++; $display("FAIL abort_transfer_count: got %0d want 11", xq.size() - x0);
    end
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    n_cmp++;
    if ({VSYNC, busy} !== 2'b00) begin
      n_err++; $display("FAIL abort_beats_start: vsync/busy=%b want 00", {VSYNC, busy});
    end
    x0 = xq.size();
    run_frame("restart", 100, -1, 0, -1, -1, -1, -1, -1, 1'b0, 1'b0);
    n_cmp++;
    if (xq.size() - x0 !== 16 || xq[x0] !== exp_addr(0, 0)) begin
      n_err++; $display("FAIL restart_clean: n=%0d first=%0d want 16/%0d", xq.size() - x0, xq[x0], exp_addr(0, 0));
    end
  endtask

  task automatic test_ignored_start_reset();
    run_frame("ign_rst", 100, -1, 0, -1, -1, 1, 2, 2, 1'b0, 1'b0);
    run_frame("post_rst", 100, -1, 0, -1, -1, -1, -1, -1, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    int x0;
    run_frame("b2b_a", 100, -1, 0, -1, -1, -1, -1, -1, 1'b0, 1'b1);
    x0 = xq.size();
    run_frame("b2b_b", 100, -1, 0, -1, -1, -1, -1, -1, 1'b1, 1'b0);
    n_cmp++;
    if (xq.size() - x0 !== 16) begin
      n_err++; $display("FAIL b2b_second_frame: got %0d transfers want 16", xq.size() - x0);
    end
  endtask

  task automatic test_random_ready();
    int x0;
    for (int k = 0; k < 3; k++) begin
      x0 = xq.size();
      run_frame("rand", 40 + 20 * k, -1, 0, -1, -1, -1, -1, -1, 1'b0, 1'b0);
      n_cmp++;
      if (xq.size() - x0 !== 16) begin
        n_err++; $display("FAIL rand_transfers[%0d]: got %0d want 16", k, xq.size() - x0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_line_bases();
    test_abort();
    test_ignored_start_reset();
    test_back_to_back();
    test_random_ready();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/frame_read_sequencer.md
# frame_read_sequencer

Frame-read controller for the image pixel pipeline. It sequences one full-frame readout: a start-up (VSYNC) interval, then for each line an HSYNC blanking interval followed by the line's pixel-pair addresses. Addresses go to the frame-memory address/read stage over a valid/ready handshake with backpressure. It replaces free-running counter timing with a stallable, abortable scheduler that reports start-of-line, end-of-line and end-of-frame.

## Interface
- WIDTH, 768: pixels per line; must be even and at least 4.
- HEIGHT, 512: lines per frame; at least 1.
- START_UP_DELAY, 100: number of cycles spent in VSYNC before the first line; at least 1.
- HSYNC_DELAY, 160: number of blanking cycles before each line; at least 1.
- ADDR_W, 19: pixel address width; must satisfy 2^ADDR_W ≥ WIDTH*HEIGHT.
- HCLK  in  1  clock; the only clock.
- HRESETn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a frame.
- abort  in  1  terminates the frame in progress.
- VSYNC  out  1  high while in the start-up interval.
- HSYNC  out  1  high while line data is being issued (DATA state).
- busy  out  1  high in any state except IDLE.
- pix_valid  out  1  a pixel-pair address is presented.
- pix_ready  in  1  downstream accepts the pair.
- pix_addr  out  ADDR_W  pixel index of the even pixel of the pair.
- pix_row  out  10  line index, 0-based.
- pix_col  out  11  even column index.
- pix_sol / pix_eol / pix_eof  out  1 each  first pair of a line / last pair of a line / last pair of the frame.
- ctrl_done  out  1  one-cycle pulse when the frame completes normally.

## Operation
- State machine states: IDLE, VSYNC, HSYNC, DATA.
- IDLE → VSYNC when start=1.
- VSYNC → HSYNC after exactly START_UP_DELAY cycles.
- HSYNC → DATA after exactly HSYNC_DELAY cycles.
- In DATA, a pair is transferred on any cycle with pix_valid & pix_ready. After each transfer, col advances by 2.
- On transfer of the pair at col = WIDTH-2:
  - col wraps to 0 and row increments.
  - Next state is HSYNC if row < HEIGHT-1, otherwise IDLE with ctrl_done.
- Address generation:
  - pix_addr = line_base + col.
  - line_base is a running register that advances by WIDTH per line. No multiplier is used.
- Outputs are Moore outputs of registered state and counters:
  - pix_valid = (state == DATA).
  - pix_sol = (col == 0).
  - pix_eol = (col == WIDTH-2).
  - pix_eof = pix_eol & (row == HEIGHT-1).
- While pix_valid=1 and pix_ready=0, every pix_* output holds stable.
- start while busy is ignored.
- start in the same cycle that ctrl_done is high is accepted, because state is already IDLE.
- abort is honoured in any state: next cycle the block is in IDLE, counters and line_base are cleared, and ctrl_done is not asserted.
- abort in the same cycle as a transfer: the transfer counts, abort wins, and no further pairs are issued.
- abort together with start in IDLE: abort wins.
- Asserting reset mid-frame returns the block to IDLE immediately. No partial-frame state survives.

## Timing
- Reset values: every output is 0; state = IDLE; all counters = 0.
- start at cycle t puts the block in VSYNC at t+1.
- With pix_ready held at 1, a frame occupies START_UP_DELAY + HEIGHT*(HSYNC_DELAY + WIDTH/2) cycles of busy.
- ctrl_done is high for exactly one cycle: the cycle after the final transfer, when state = IDLE.
- Throughput: one pair per cycle when pix_ready=1. There are no bubbles inside a line.
- Counter widths: sync counter 9 bits; row 10 bits; col 11 bits.

## Configuration
- ROW_FLIP_EN defined:
  - Lines are addressed bottom-up to match frame memory written last-row-first.
  - line_base starts at (HEIGHT-1)*WIDTH and decreases by WIDTH per line.
  - pix_row still counts 0 upward.
- ROW_FLIP_EN undefined: line_base starts at 0 and increases by WIDTH per line.

## Structure
- Package frame_seq_pkg holds:
  - the state encoding (IDLE=2'b00, VSYNC=2'b01, HSYNC=2'b10, DATA=2'b11);
  - the row and col width constants.
- Sub-module frame_seq_timer: a loadable down-counter with a terminal-count flag and a synchronous clear, shared by the VSYNC and HSYNC intervals.

## Test plan
Bench parameters: WIDTH=8, HEIGHT=4, START_UP_DELAY=3, HSYNC_DELAY=2.
- Nominal frame: pulse start, pix_ready=1.
  - VSYNC high for 3 cycles; each line is 2 blanking cycles then addresses base+0, +2, +4, +6.
  - 16 transfers, last address 30 with pix_eof=1.
  - ctrl_done pulses at cycle 28 after start; busy high for 27 cycles.
- Backpressure: drop pix_ready for 5 cycles while address 10 is presented.
  - Address 10, row 1 and col 2 stay stable with pix_valid=1.
  - Frame completes 5 cycles later than nominal.
- ROW_FLIP_EN build:
  - First address is 24 with pix_sol=1.
  - Line 1 starts at 16.
  - Final transfer is address 6 with pix_eof=1.
- Abort: assert abort while presenting row 2, col 4.
  - Next cycle: IDLE, pix_valid=0, busy=0, no ctrl_done.
  - A following start restarts cleanly from address 0.
- Ignored start / reset: pulse start during HSYNC and observe no effect. Then assert HRESETn=0 mid-DATA.
  - All outputs go to 0 asynchronously.
- Back-to-back frames: pulse start in the ctrl_done cycle.
  - VSYNC rises the next cycle and a second 16-transfer frame follows.
